// File: rtl/inv_mix_column.sv
// Byte-serial AES InvMixColumns stage: gathers a 4-byte column, multiplies it by the
// inverse MDS matrix {0e,0b,0d,09} (or passes it through on bypass blocks), and streams it out.
module inv_mix_column (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] data_in,
    input  logic       bypass,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] data_out,
    output logic       out_last
);

    typedef enum logic [1:0] {LOAD, COMPUTE, SEND} state_t;

    state_t     state_q, state_d;
    logic [1:0] row_cnt_q, row_cnt_d;
    logic [1:0] col_cnt_q, col_cnt_d;
    logic       blk_bypass_q, blk_bypass_d;
    logic [7:0] a_q [4];
    logic [7:0] b_q [4];
    logic [7:0] mul9 [4];
    logic [7:0] mulb [4];
    logic [7:0] muld [4];
    logic [7:0] mule [4];
    logic [7:0] mix  [4];
    logic       in_fire;

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    assign in_fire = in_valid && (state_q == LOAD);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            logic [7:0] x2, x4, x8;
            assign x2 = xt(a_q[gi]);
            assign x4 = xt(x2);
            assign x8 = xt(x4);
            assign mul9[gi] = x8 ^ a_q[gi];
            assign mulb[gi] = x8 ^ x2 ^ a_q[gi];
            assign muld[gi] = x8 ^ x4 ^ a_q[gi];
            assign mule[gi] = x8 ^ x4 ^ x2;
        end

        // Row i of the circulant matrix picks 0e/0b/0d/09 from a rotated column.
        for (gi = 0; gi < 4; gi++) begin : g_mix
            assign mix[gi] = mule[gi] ^ mulb[(gi + 1) % 4]
                           ^ muld[(gi + 2) % 4] ^ mul9[(gi + 3) % 4];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_q[gi] <= 8'h00;
                    b_q[gi] <= 8'h00;
                end else begin
                    if (in_fire && (row_cnt_q == 2'(gi)))
                        a_q[gi] <= data_in;
                    if (state_q == COMPUTE)
                        b_q[gi] <= blk_bypass_q ? a_q[gi] : mix[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LOAD;
            row_cnt_q    <= 2'd0;
            col_cnt_q    <= 2'd0;
            blk_bypass_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            col_cnt_q    <= col_cnt_d;
            blk_bypass_q <= blk_bypass_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        col_cnt_d    = col_cnt_q;
        blk_bypass_d = blk_bypass_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Only the first byte of a block decides whether the block is mixed.
                    if (row_cnt_q == 2'd0 && col_cnt_q == 2'd0)
                        blk_bypass_d = bypass;
                    row_cnt_d = row_cnt_q + 2'd1;
                    if (row_cnt_q == 2'd3)
                        state_d = COMPUTE;
                end
            end
            COMPUTE: state_d = SEND;
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    row_cnt_d = row_cnt_q + 2'd1;
                    if (row_cnt_q == 2'd3) begin
                        col_cnt_d = col_cnt_q + 2'd1;
                        state_d   = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign data_out = b_q[row_cnt_q];
    assign out_last = out_valid && (col_cnt_q == 2'd3) && (row_cnt_q == 2'd3);

endmodule

// File: tb/tb_inv_mix_column.sv
// Scoreboard bench for inv_mix_column: the driver queues hand-computed expected bytes,
// and a monitor pops and compares them on every output transfer.
module tb_inv_mix_column;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data_in = 8'h00;
    logic       bypass = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] data_out;
    logic       out_last;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tb_col   = 0;
    int   n_out    = 0;

    inv_mix_column dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .bypass(bypass),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, req);
        end
    endtask

    // Monitor: the output stream is sampled on the falling edge, ahead of the transfer edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %02h last=%0b, expected nothing", data_out, out_last);
                end else begin
                    e = sb_q.pop_front();
                    $display("out #%0d: data=%02h last=%0b (expected %02h last=%0b)",
                             n_out, data_out, out_last, e.d, e.last);
                    check("data_out", data_out, e.d);
                    check("out_last", {7'd0, out_last}, {7'd0, e.last});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic byp, input int gap);
        int waited;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        data_in  = d;
        bypass   = byp;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_ready_timeout: got 0, expected 1 within 200 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bypass   = 1'($urandom_range(1));
    endtask

    // Column as {row0,row1,row2,row3}; bypass is driven only meaningfully on block byte 0.
    task automatic send_column(input logic [31:0] col_in, input logic [31:0] col_exp,
                               input logic byp_first, input int gap);
        logic [31:0] cin;
        logic [31:0] cexp;
        logic        byp;
        cin  = col_in;
        cexp = col_exp;
        for (int r = 0; r < 4; r++)
            sb_q.push_back('{d: cexp[31 - 8*r -: 8], last: (tb_col == 3 && r == 3)});
        for (int r = 0; r < 4; r++) begin
            byp = (r == 0 && tb_col == 0) ? byp_first : 1'($urandom_range(1));
            send_byte(cin[31 - 8*r -: 8], byp, gap);
        end
        $display("column %08h sent (block col %0d), expecting %08h", cin, tb_col, cexp);
        tb_col = (tb_col + 1) % 4;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (sb_q.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes pending, expected 0", sb_q.size());
        end
    endtask

    task automatic wait_out_valid();
        int waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("out_valid_seen", {7'd0, out_valid}, 8'd1);
    endtask

    initial begin
        // Reset values
        #2;
        check("reset_in_ready", {7'd0, in_ready}, 8'd1);
        check("reset_out_valid", {7'd0, out_valid}, 8'd0);
        check("reset_data_out", data_out, 8'h00);
        check("reset_out_last", {7'd0, out_last}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Block A: four known columns, out_last on byte 15; first column checks latency
        send_column(32'h8e4da1bc, 32'hdb135345, 1'b0, 0);
        @(negedge clk);
        check("latency_compute_gap", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        check("latency_out_valid", {7'd0, out_valid}, 8'd1);
        check("latency_first_byte", data_out, 8'hdb);
        wait_drain();
        send_column(32'h9fdc589d, 32'hf20a225c, 1'b0, 0);
        send_column(32'h01010101, 32'h01010101, 1'b0, 0);
        send_column(32'hc6c6c6c6, 32'hc6c6c6c6, 1'b0, 0);
        wait_drain();

        // Block B: bypass sampled on byte 0, random bypass afterwards
        send_column(32'h8e4da1bc, 32'h8e4da1bc, 1'b1, 0);
        send_column(32'h9fdc589d, 32'h9fdc589d, 1'b1, 0);
        send_column(32'h3a7f0055, 32'h3a7f0055, 1'b1, 0);
        send_column(32'hff12c0de, 32'hff12c0de, 1'b1, 0);
        wait_drain();

        // Block C: bypass off again, normal transform
        send_column(32'h9fdc589d, 32'hf20a225c, 1'b0, 0);
        send_column(32'h8e4da1bc, 32'hdb135345, 1'b0, 0);
        send_column(32'hc6c6c6c6, 32'hc6c6c6c6, 1'b0, 0);
        send_column(32'h01010101, 32'h01010101, 1'b0, 0);
        wait_drain();

        // Block D col 0: backpressure after two output bytes
        send_column(32'h8e4da1bc, 32'hdb135345, 1'b0, 0);
        wait_out_valid();
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data_out", data_out, 8'h53);
            check("bp_out_last", {7'd0, out_last}, 8'd0);
            check("bp_in_ready", {7'd0, in_ready}, 8'd0);
            check("bp_out_valid", {7'd0, out_valid}, 8'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Block D cols 1..3: input gaps, then the rest of the block
        send_column(32'h8e4da1bc, 32'hdb135345, 1'b0, 1);
        send_column(32'h01010101, 32'h01010101, 1'b0, 2);
        send_column(32'hc6c6c6c6, 32'hc6c6c6c6, 1'b0, 0);
        wait_drain();

        // Block E: bypass block, reset during SEND after two output bytes
        send_column(32'h8e4da1bc, 32'h8e4da1bc, 1'b1, 0);
        wait_out_valid();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        tb_col = 0;
        #1;
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_in_ready", {7'd0, in_ready}, 8'd1);
        check("rst_out_last", {7'd0, out_last}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_column(32'h9fdc589d, 32'hf20a225c, 1'b0, 0);
        wait_drain();

        repeat (5) @(posedge clk);
        #1;
        check("final_out_valid", {7'd0, out_valid}, 8'd0);
        check("final_outputs_seen", 8'(n_out), 8'd70);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
